// File: rtl/seg7_pkg.sv
// Shared types and the active-low seven-segment font for the scan driver.
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] nibble_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  // Active-low patterns, bit0=a .. bit6=g, indexed by hex digit
  localparam seg7_t FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg7_t font_of(nibble_t nib);
    return FONT[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/load input bundle and display pin outputs of the seven-segment scan driver.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  seg7_t                   seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output value, load,
    input  seg, an, frame_tick
  );

  modport slave (
    input  value, load,
    output seg, an, frame_tick
  );

endinterface

// File: rtl/seg7_font_rom.sv
// Combinational nibble-to-segment lookup, active-low.
module seg7_font_rom
  import seg7_pkg::*;
(
  input  nibble_t nib,
  output seg7_t   seg_c
);

  assign seg_c = font_of(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-boundary double buffering.
// Optional leading-zero blanking is built when SEG7_LZB_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         stg_q, stg_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic                  pend_q, pend_d;
  seg7_t                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  tc_c;
  logic                  last_idx_c;
  logic                  boundary_c;
  logic                  guard_c;
  nibble_t               sel_nib_c;
  seg7_t                 font_seg_c;

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] lz_blank_c;
  logic                  zero_run_c;
  logic                  sel_blank_c;

  // A digit blanks when it and every more-significant nibble are zero; digit 0 always shows
  always_comb begin
    zero_run_c = 1'b1;
    lz_blank_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run_c    = zero_run_c && (disp_q[4*i +: 4] == 4'h0);
      lz_blank_c[i] = (i != 0) && zero_run_c;
    end
  end
`endif

  // Prescaler, digit index and double-buffered value registers
  always_comb begin
    tc_c       = (pcnt_q == PW'(CLK_DIV - 1));
    last_idx_c = (idx_q == IW'(NUM_DIGITS - 1));
    boundary_c = tc_c && last_idx_c;

    pcnt_d = tc_c ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (tc_c) begin
      idx_d = last_idx_c ? '0 : idx_q + IW'(1);
    end

    stg_d  = stg_q;
    pend_d = pend_q;
    disp_d = disp_q;
    if (bus.load) begin
      stg_d  = bus.value;
      pend_d = 1'b1;
    end
    // A load coinciding with the boundary bypasses staging so it is not lost a frame
    if (boundary_c) begin
      if (bus.load) begin
        disp_d = bus.value;
      end else if (pend_q) begin
        disp_d = stg_q;
      end
      pend_d = 1'b0;
    end
  end

  // Pick the nibble (and its blank flag) for the digit currently being scanned
  always_comb begin
    sel_nib_c = '0;
`ifdef SEG7_LZB_EN
    sel_blank_c = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib_c = disp_q[4*i +: 4];
`ifdef SEG7_LZB_EN
        sel_blank_c = lz_blank_c[i];
`endif
      end
    end
  end

  seg7_font_rom u_font (
    .nib   (sel_nib_c),
    .seg_c (font_seg_c)
  );

  // Output next-state: anodes dark during the guard window to suppress ghosting
  always_comb begin
    guard_c = (pcnt_q < PW'(GUARD_CYCLES));
    an_d    = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      an_d[i] = guard_c || (idx_q != IW'(i));
    end
`ifdef SEG7_LZB_EN
    seg_d = sel_blank_c ? SEG_OFF : font_seg_c;
`else
    seg_d = font_seg_c;
`endif
    frame_tick_d = (pcnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      stg_q        <= '0;
      disp_q       <= '0;
      pend_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      stg_q        <= stg_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
